// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : rand_range_sampler
// Purpose  : Turns raw random words into uniform integers in [0, BOUND) by
//            mask-and-reject sampling, without a divider. A bound is taken
//            from the client, words are pulled from the random source one at
//            a time, and the first masked word below the bound is returned.
// Ports    :
//   CLK                 clock, all state updates on posedge
//   RESET               asynchronous active-high reset
//   REQ_WRITE           requested bound (0 selects the full 2^WIDTH range)
//   REQ_WRITE_VALID     client presents a bound
//   REQ_WRITE_CONSUMED  bound is taken this cycle (high whenever idle)
//   RESP_READ           sampled result
//   RESP_READ_VALID     result available
//   RESP_READ_CONSUMED  client takes the result
//   RAND_REQ            one-cycle strobe asking the source for a new word
//   RAND_WORD           current source word, valid the cycle after RAND_REQ
//   REJECT_COUNT        saturating total of rejected draws
// Revision : 1.0 - initial release
// ============================================================================
module rand_range_sampler #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     REQ_WRITE,
    input  logic                 REQ_WRITE_VALID,
    output logic                 REQ_WRITE_CONSUMED,
    output logic [WIDTH-1:0]     RESP_READ,
    output logic                 RESP_READ_VALID,
    input  logic                 RESP_READ_CONSUMED,
    output logic                 RAND_REQ,
    input  logic [WIDTH-1:0]     RAND_WORD,
    output logic [CNT_WIDTH-1:0] REJECT_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CHECK = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     bound_q;
    logic [WIDTH-1:0]     mask_q;
    logic [WIDTH-1:0]     resp_q;
    logic                 resp_valid_q;
    logic                 rand_req_q;
    logic [CNT_WIDTH-1:0] rej_cnt_q;

    logic [WIDTH-1:0]     bound_m1;
    logic [WIDTH-1:0]     mask_d;
    logic [WIDTH-1:0]     sample_d;
    logic                 accept_d;
    logic [CNT_WIDTH-1:0] rej_cnt_d;

    // Mask = every bit at and below the MSB of (bound - 1). A bound of 0
    // wraps to all ones (full range); a bound of 1 gives an empty mask.
    always_comb begin
        bound_m1 = REQ_WRITE - WIDTH'(1);
        mask_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_d[i] = |(bound_m1 >> i);
        end
    end

    // Masked draw and acceptance test. With the mask no wider than needed,
    // at least half of the masked values lie below the bound.
    always_comb begin
        sample_d  = RAND_WORD & mask_q;
        accept_d  = (bound_q == '0) || (sample_d < bound_q);
        rej_cnt_d = (&rej_cnt_q) ? rej_cnt_q : rej_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            bound_q      <= '0;
            mask_q       <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            rand_req_q   <= 1'b0;
            rej_cnt_q    <= '0;
        end else begin
            // The strobe is raised only on entry to FETCH, so it lasts
            // exactly one cycle and comes straight from a flop.
            rand_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (REQ_WRITE_VALID) begin
                        bound_q    <= REQ_WRITE;
                        mask_q     <= mask_d;
                        rand_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Source updates its word at the end of this cycle.
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (accept_d) begin
                        resp_q       <= sample_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_HOLD;
                    end else begin
                        rej_cnt_q  <= rej_cnt_d;
                        rand_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (RESP_READ_CONSUMED) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign REQ_WRITE_CONSUMED = (state_q == S_IDLE);
    assign RESP_READ          = resp_q;
    assign RESP_READ_VALID    = resp_valid_q;
    assign RAND_REQ           = rand_req_q;
    assign REJECT_COUNT       = rej_cnt_q;

endmodule
`default_nettype wire
